// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: two-stage pipelined bitwise logic unit with valid/ready handshake,
// registered result flags and a wrapping count of delivered results.
module logic_unit_pipe #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         in_op,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_result,
    output logic               out_zero,
    output logic               out_ones,
    output logic               out_parity,
    output logic [COUNT_W-1:0] done_count
);
    logic [WIDTH-1:0] s1_data;
    logic [WIDTH-1:0] f;
    logic             s1_valid;
    logic             s1_ready;
    logic             s2_ready;

    assign s2_ready = !out_valid || out_ready;
    assign s1_ready = !s1_valid || s2_ready;
    assign in_ready = s1_ready;

    always_comb begin
        case (in_op)
            3'b000:  f = in_a & in_b;
            3'b001:  f = in_a | in_b;
            3'b010:  f = ~in_a;
            3'b011:  f = ~(in_a & in_b);
            3'b100:  f = ~(in_a | in_b);
            3'b101:  f = in_a ^ in_b;
            3'b110:  f = ~(in_a ^ in_b);
            default: f = in_a;
        endcase
    end

    // Valid bits follow the upstream valid whenever the stage can take a beat;
    // data registers only load on an actual transfer so outputs hold under stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid   <= 1'b0;
            s1_data    <= '0;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_zero   <= 1'b1;
            out_ones   <= 1'b0;
            out_parity <= 1'b0;
            done_count <= '0;
        end else begin
            if (s1_ready) s1_valid <= in_valid;
            if (in_valid && s1_ready) s1_data <= f;
            if (s2_ready) out_valid <= s1_valid;
            if (s1_valid && s2_ready) begin
                out_result <= s1_data;
                out_zero   <= ~|s1_data;
                out_ones   <= &s1_data;
                out_parity <= ^s1_data;
            end
            if (out_valid && out_ready) done_count <= done_count + COUNT_W'(1);
        end
    end
endmodule

// File: tb/tb_logic_unit_pipe.sv
// tb_logic_unit_pipe: scoreboard bench for logic_unit_pipe across 8-bit, 1-bit and
// narrow-counter configurations.
module tb_logic_unit_pipe;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit mon_en = 1'b0;

    logic        v0 = 1'b0, rdy0, or0 = 1'b1, ov0, z0, o0, p0;
    logic [2:0]  op0 = '0;
    logic [7:0]  a0 = '0, b0 = '0, r0;
    logic [15:0] dc0;
    logic [7:0]  q0[$];

    logic        v1 = 1'b0, rdy1, or1 = 1'b1, ov1, z1, o1, p1;
    logic [2:0]  op1 = '0;
    logic [0:0]  a1 = '0, b1 = '0, r1;
    logic [5:0]  dc1;

    logic        v2 = 1'b0, rdy2, or2 = 1'b1, ov2, z2, o2, p2;
    logic [7:0]  r2;
    logic [2:0]  dc2;

    logic_unit_pipe #(.WIDTH(8), .COUNT_W(16)) u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(v0), .in_ready(rdy0), .in_op(op0),
        .in_a(a0), .in_b(b0), .out_valid(ov0), .out_ready(or0), .out_result(r0),
        .out_zero(z0), .out_ones(o0), .out_parity(p0), .done_count(dc0)
    );

    logic_unit_pipe #(.WIDTH(1), .COUNT_W(6)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_ready(rdy1), .in_op(op1),
        .in_a(a1), .in_b(b1), .out_valid(ov1), .out_ready(or1), .out_result(r1),
        .out_zero(z1), .out_ones(o1), .out_parity(p1), .done_count(dc1)
    );

    logic_unit_pipe #(.WIDTH(8), .COUNT_W(3)) u2 (
        .clk(clk), .rst_n(rst_n), .in_valid(v2), .in_ready(rdy2), .in_op(3'b001),
        .in_a(8'h0F), .in_b(8'hF0), .out_valid(ov2), .out_ready(or2), .out_result(r2),
        .out_zero(z2), .out_ones(o2), .out_parity(p2), .done_count(dc2)
    );

    function automatic logic [7:0] model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            3'd0: return a & b;
            3'd1: return a | b;
            3'd2: return ~a;
            3'd3: return ~(a & b);
            3'd4: return ~(a | b);
            3'd5: return a ^ b;
            3'd6: return ~(a ^ b);
            default: return a;
        endcase
    endfunction

    // Output side of the 8-bit scoreboard: every delivered beat is popped and checked.
    always @(negedge clk) begin
        if (mon_en && rst_n && ov0 && or0) begin
            checks++;
            if (q0.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected got=%h expected=none", r0);
            end else begin
                logic [7:0] e;
                e = q0.pop_front();
                if ({r0, z0, o0, p0} !== {e, e == 8'h00, e == 8'hFF, ^e}) begin
                    errors++;
                    $display("FAIL sb_result got=%h z%b o%b p%b expected=%h z%b o%b p%b",
                             r0, z0, o0, p0, e, e == 8'h00, e == 8'hFF, ^e);
                end
            end
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic drain0(input int expected_count);
        int c;
        c = 0;
        v0 = 1'b0;
        or0 = 1'b1;
        while (q0.size() != 0 && c < 100) begin
            step();
            c++;
        end
        step();
        checks++;
        if (q0.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout got=%0d pending expected=0", q0.size());
        end
        checks++;
        if (dc0 !== 16'(expected_count)) begin
            errors++;
            $display("FAIL done_count got=%0d expected=%0d", dc0, expected_count);
        end
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({ov0, r0, z0, o0, p0, dc0} !== {1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 16'h0}) begin
            errors++;
            $display("FAIL reset_state got=%b_%h_%b%b%b_%h expected=0_00_100_0000",
                     ov0, r0, z0, o0, p0, dc0);
        end
        checks++;
        if ({ov1, r1, z1, o1, p1, dc1} !== {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'h0}) begin
            errors++;
            $display("FAIL reset_state_w1 got=%b_%b_%b%b%b_%h expected=0_0_100_00",
                     ov1, r1, z1, o1, p1, dc1);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (rdy0 !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready got=%b expected=1", rdy0);
        end
        step();
    endtask

    task automatic test_op_sweep;
        logic [7:0] sweep [8];
        sweep = '{8'h00, 8'hFF, 8'h3A, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'hC5};
        mon_en = 1'b1;
        or0 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            v0 = 1'b1;
            op0 = 3'(i);
            a0 = 8'hC5;
            b0 = 8'h3A;
            @(negedge clk);
            checks++;
            if (ov0 !== (i >= 2)) begin
                errors++;
                $display("FAIL sweep_latency cycle=%0d got=%b expected=%b", i, ov0, i >= 2);
            end
            if (rdy0) q0.push_back(sweep[i]);
            step();
        end
        drain0(8);
    endtask

    task automatic test_back_pressure;
        int acc, c;
        logic [7:0] held;
        acc = 0;
        or0 = 1'b0;
        v0 = 1'b1;
        op0 = 3'($urandom); a0 = 8'($urandom); b0 = 8'($urandom);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (v0 && rdy0) begin
                q0.push_back(model(op0, a0, b0));
                acc++;
            end
            step();
            if (acc > 0 && rdy0) begin
                op0 = 3'($urandom); a0 = 8'($urandom); b0 = 8'($urandom);
            end
        end
        @(negedge clk);
        checks++;
        if (acc != 2 || rdy0 !== 1'b0 || ov0 !== 1'b1) begin
            errors++;
            $display("FAIL bp_fill got acc=%0d in_ready=%b out_valid=%b expected acc=2 in_ready=0 out_valid=1",
                     acc, rdy0, ov0);
        end
        held = r0;
        for (int i = 0; i < 3; i++) begin
            step();
            @(negedge clk);
            checks++;
            if (r0 !== held) begin
                errors++;
                $display("FAIL bp_hold got=%h expected=%h", r0, held);
            end
        end
        step();
        op0 = 3'($urandom); a0 = 8'($urandom); b0 = 8'($urandom);
        or0 = 1'b1;
        @(negedge clk);
        checks++;
        if (rdy0 !== 1'b1) begin
            errors++;
            $display("FAIL bp_single_release got in_ready=%b expected=1", rdy0);
        end
        if (v0 && rdy0) begin
            q0.push_back(model(op0, a0, b0));
            acc++;
        end
        step();
        or0 = 1'b0;
        op0 = 3'($urandom); a0 = 8'($urandom); b0 = 8'($urandom);
        @(negedge clk);
        checks++;
        if (rdy0 !== 1'b0 || acc != 3) begin
            errors++;
            $display("FAIL bp_single_admit got in_ready=%b acc=%0d expected in_ready=0 acc=3", rdy0, acc);
        end
        step();
        or0 = 1'b1;
        c = 0;
        while (acc < 5 && c < 50) begin
            @(negedge clk);
            if (v0 && rdy0) begin
                q0.push_back(model(op0, a0, b0));
                acc++;
            end
            step();
            op0 = 3'($urandom); a0 = 8'($urandom); b0 = 8'($urandom);
            c++;
        end
        drain0(13);
    endtask

    task automatic test_random;
        int sent, c;
        sent = 0;
        c = 0;
        while (sent < 1000 && c < 20000) begin
            v0 = ($urandom_range(99) < 70);
            or0 = ($urandom_range(99) < 60);
            op0 = 3'($urandom); a0 = 8'($urandom); b0 = 8'($urandom);
            @(negedge clk);
            if (v0 && rdy0) begin
                q0.push_back(model(op0, a0, b0));
                sent++;
            end
            step();
            c++;
        end
        checks++;
        if (sent != 1000) begin
            errors++;
            $display("FAIL random_timeout got=%0d sent expected=1000", sent);
        end
        drain0(1013);
    endtask

    task automatic test_one_bit;
        logic [3:0] tt [8];
        logic [0:0] q1[$];
        logic [4:0] idx;
        int c;
        tt = '{4'b1000, 4'b1110, 4'b0011, 4'b0111, 4'b0001, 4'b0110, 4'b1001, 4'b1100};
        idx = '0;
        c = 0;
        or1 = 1'b1;
        while (c < 40) begin
            v1 = (c < 32);
            {op1, a1, b1} = idx;
            @(negedge clk);
            if (ov1 && or1) begin
                logic [0:0] e;
                checks++;
                e = (q1.size() != 0) ? q1.pop_front() : 1'bx;
                if ({r1, z1, o1, p1} !== {e, ~e, e, e}) begin
                    errors++;
                    $display("FAIL one_bit got=%b z%b o%b p%b expected=%b", r1, z1, o1, p1, e);
                end
            end
            if (v1 && rdy1) begin
                q1.push_back(tt[op1][{a1, b1}]);
                idx++;
            end
            step();
            c++;
        end
        checks++;
        if (q1.size() != 0 || dc1 !== 6'd32) begin
            errors++;
            $display("FAIL one_bit_count got pending=%0d done=%0d expected pending=0 done=32", q1.size(), dc1);
        end
    endtask

    task automatic test_count_wrap;
        or2 = 1'b1;
        v2 = 1'b1;
        repeat (10) step();
        v2 = 1'b0;
        repeat (3) step();
        @(negedge clk);
        checks++;
        if (dc2 !== 3'd2 || r2 !== 8'hFF || o2 !== 1'b1) begin
            errors++;
            $display("FAIL count_wrap got done=%0d result=%h ones=%b expected done=2 result=ff ones=1", dc2, r2, o2);
        end
    endtask

    task automatic test_reset_mid;
        or0 = 1'b0;
        v0 = 1'b1;
        op0 = 3'd0; a0 = 8'hAA; b0 = 8'hFF;
        repeat (3) step();
        #1 rst_n = 1'b0;
        #1;
        q0.delete();
        checks++;
        if (ov0 !== 1'b0 || dc0 !== 16'h0) begin
            errors++;
            $display("FAIL reset_mid got out_valid=%b done=%0d expected out_valid=0 done=0", ov0, dc0);
        end
        v0 = 1'b0;
        or0 = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        v0 = 1'b1;
        op0 = 3'd5; a0 = 8'hFF; b0 = 8'h0F;
        @(negedge clk);
        if (rdy0) q0.push_back(8'hF0);
        step();
        v0 = 1'b0;
        @(negedge clk);
        checks++;
        if (ov0 !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_stale got out_valid=%b result=%h expected out_valid=0", ov0, r0);
        end
        step();
        @(negedge clk);
        checks++;
        if (ov0 !== 1'b1 || r0 !== 8'hF0) begin
            errors++;
            $display("FAIL reset_mid_first got out_valid=%b result=%h expected out_valid=1 result=f0", ov0, r0);
        end
        drain0(1);
    endtask

    initial begin
        test_reset();
        test_op_sweep();
        test_back_pressure();
        test_random();
        test_one_bit();
        test_count_wrap();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
